// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and constants for the data-memory responder.
//   dmem_state_t - responder FSM states (IDLE, WAIT, RESP)
//   DMEM_DATA_W  - data word width
//   DMEM_BE_W    - byte-enable width
//   DMEM_CNT_W   - wait-state counter width (WAIT_CYC range 0..15)
//   addr_err()   - misaligned / out-of-range address detection
package dmem_pkg;

  localparam int DMEM_DATA_W = 32;
  localparam int DMEM_BE_W   = 4;
  localparam int DMEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_t;

  // An address is bad when it is not word aligned or has any bit set at or
  // above the array's byte-address width.
  function automatic logic addr_err(input logic [DMEM_DATA_W-1:0] addr,
                                    input int                     addr_w);
    logic [DMEM_DATA_W-1:0] hi;
    hi = addr >> addr_w;
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous word RAM with per-byte write enables and a
// registered read port. One access per enabled edge: a write when we_i is
// set, otherwise a read into rdata_o. Contents are never cleared.
// Ports:
//   clk_i    in   clock
//   en_i     in   access strobe
//   we_i     in   1 = byte-masked write, 0 = read
//   addr_i   in   word index
//   wdata_i  in   write data
//   be_i     in   byte enables for writes
//   rdata_o  out  registered read data (holds until the next read)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int WORD_AW = 8
) (
  input  logic                   clk_i,
  input  logic                   en_i,
  input  logic                   we_i,
  input  logic [WORD_AW-1:0]     addr_i,
  input  logic [DMEM_DATA_W-1:0] wdata_i,
  input  logic [DMEM_BE_W-1:0]   be_i,
  output logic [DMEM_DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 1 << WORD_AW;

  logic [DMEM_DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int b = 0; b < DMEM_BE_W; b++) begin
          if (be_i[b]) begin
            mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end else begin
        rdata_o <= mem[addr_i];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side responder for the CPU load/store port.
// Accepts one request at a time (valid/ready), holds it for WAIT_CYC wait
// states, performs the access on an internal word array, then presents a
// response (read data + error flag) until the requester takes it.
// Optional feature macro: DMEM_RESP_ERRCHK_EN
//   defined   - misaligned or out-of-range addresses flag rsp_err_o,
//               suppress stores and return 0 for loads
//   undefined - rsp_err_o is 0 and the address wraps modulo the array size
// Ports:
//   clk_i        in   clock
//   rst_i        in   synchronous active-high reset
//   req_valid_i  in   request present
//   req_ready_o  out  responder idle and able to accept
//   req_we_i     in   1 = store, 0 = load
//   req_addr_i   in   byte address
//   req_wdata_i  in   store data
//   req_be_i     in   store byte enables
//   rsp_valid_o  out  response present
//   rsp_ready_i  in   requester takes the response
//   rsp_rdata_o  out  load data, 0 for stores and errors
//   rsp_err_o    out  access error
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   req_we_i,
  input  logic [31:0]            req_addr_i,
  input  logic [DMEM_DATA_W-1:0] req_wdata_i,
  input  logic [DMEM_BE_W-1:0]   req_be_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DMEM_DATA_W-1:0] rsp_rdata_o,
  output logic                   rsp_err_o
);

  localparam int                    WORD_AW   = ADDR_W - 2;
  localparam logic [DMEM_CNT_W-1:0] WAIT_INIT = DMEM_CNT_W'(WAIT_CYC);

  dmem_state_t             state_q, state_d;
  logic [DMEM_CNT_W-1:0]   cnt_q, cnt_d;
  logic                    accept;
  logic                    access;
  logic                    access_en;
  logic                    req_err;

  logic                    we_q;
  logic [WORD_AW-1:0]      word_q;
  logic [DMEM_DATA_W-1:0]  wdata_q;
  logic [DMEM_BE_W-1:0]    be_q;
  logic                    err_q;

  logic                    rsp_load_q;
  logic                    rsp_err_q;
  logic [DMEM_DATA_W-1:0]  arr_rdata;

`ifdef DMEM_RESP_ERRCHK_EN
  assign req_err = addr_err(req_addr_i, ADDR_W);
`else
  // Only the word-index bits matter; the rest are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^req_addr_i;
  assign req_err     = 1'b0;
`endif

  // FSM next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    access      = 1'b0;
    req_ready_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          accept  = 1'b1;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          access  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture: only the accepted request is used afterwards
  always_ff @(posedge clk_i) begin
    if (accept) begin
      we_q    <= req_we_i;
      word_q  <= req_addr_i[ADDR_W-1:2];
      wdata_q <= req_wdata_i;
      be_q    <= req_be_i;
      err_q   <= req_err;
    end
  end

  // Response flags: load data is exposed only for good loads, and both
  // flags drop on the response handshake so the outputs return to 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rsp_load_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else if (access) begin
      rsp_load_q <= ~we_q & ~err_q;
      rsp_err_q  <= err_q;
    end else if (rsp_valid_o && rsp_ready_i) begin
      rsp_load_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end
  end

  // A reset on the access edge must not let a pending store reach the array.
  assign access_en = access & ~rst_i;

  dmem_array #(
    .WORD_AW (WORD_AW)
  ) u_array (
    .clk_i   (clk_i),
    .en_i    (access_en),
    .we_i    (we_q & ~err_q),
    .addr_i  (word_q),
    .wdata_i (wdata_q),
    .be_i    (be_q),
    .rdata_o (arr_rdata)
  );

  assign rsp_rdata_o = rsp_load_q ? arr_rdata : '0;
  assign rsp_err_o   = rsp_err_q;

endmodule
